// File: rtl/button_debounce_pulse.sv
// -----------------------------------------------------------------------------
// button_debounce_pulse
//
// Turns a raw, bouncy push-button level into clean single-cycle strobes. Its
// main consumer is the 4-bit counter's count-enable: one btn_pulse per press.
//
// Datapath:
//   btn_in -> 2-flop synchronizer -> debounce FSM -> registered outputs
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset (0 = in reset)
//   btn_in       in   raw asynchronous button level, 1 = pressed
//   btn_level    out  debounced button level (registered)
//   btn_pulse    out  one-cycle strobe per accepted press (plus repeats when
//                     auto-repeat is built in)
//   btn_release  out  one-cycle strobe per accepted release
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles the synchronized input must stay stable before a
//                    press or release is accepted (>= 2)
//   REPEAT_DELAY     auto-repeat only: cycles from the press pulse to the
//                    first repeat pulse (>= 2)
//   REPEAT_PERIOD    auto-repeat only: cycles between later repeats (>= 2)
//
// Build option:
//   AUTOREPEAT_EN    when defined, a repeat timer runs while the button is
//                    held and emits extra btn_pulse strobes. When undefined
//                    the repeat logic is not built and the REPEAT_* values
//                    have no effect on the hardware.
//
// Latency with a stable input: btn_pulse (and btn_level) rise on the
// (DEBOUNCE_CYCLES+3)th rising edge counting the first edge that samples
// btn_in=1: two edges of synchronizer, one edge to leave IDLE, then
// DEBOUNCE_CYCLES-1 counting edges and the accepting edge. Release is
// symmetric.
// -----------------------------------------------------------------------------
module button_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_release
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks. The repeat values are checked in every
  // build so that a configuration stays valid if auto-repeat is later enabled.
  // ---------------------------------------------------------------------------
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("button_debounce_pulse: DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_DELAY < 2) begin : g_bad_repeat_delay
    $error("button_debounce_pulse: REPEAT_DELAY must be >= 2");
  end
  if (REPEAT_PERIOD < 2) begin : g_bad_repeat_period
    $error("button_debounce_pulse: REPEAT_PERIOD must be >= 2");
  end

  // ---------------------------------------------------------------------------
  // Counter sizing: wide enough for the largest count actually used, plus one
  // bit of headroom. Counters clear on every state change, so they never wrap.
  // ---------------------------------------------------------------------------
`ifdef AUTOREPEAT_EN
  localparam int unsigned RptMax    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
  localparam int unsigned MaxCycles = (RptMax > DEBOUNCE_CYCLES) ? RptMax : DEBOUNCE_CYCLES;
`else
  localparam int unsigned MaxCycles = DEBOUNCE_CYCLES;
`endif
  localparam int unsigned CntW = $clog2(MaxCycles) + 1;

  localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

`ifdef AUTOREPEAT_EN
  localparam logic [CntW-1:0] RptDelayLast  = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] RptPeriodLast = CntW'(REPEAT_PERIOD - 1);
`endif

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    StIdle        = 2'd0,
    StPressWait   = 2'd1,
    StHeld        = 2'd2,
    StReleaseWait = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            pulse_q, pulse_d;
  logic            release_q, release_d;

  // Two-flop synchronizer; only sync_q is ever looked at by the FSM.
  logic            sync1_q;
  logic            sync_q;

`ifdef AUTOREPEAT_EN
  // Repeat timer. rpt_first_q selects the initial REPEAT_DELAY interval; after
  // the first repeat (or after a bounce back into HELD) the period applies.
  logic [CntW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic            rpt_first_q, rpt_first_d;
  logic [CntW-1:0] rpt_last;

  assign rpt_last = rpt_first_q ? RptDelayLast : RptPeriodLast;
`endif

  // ---------------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync_q  <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      pulse_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      release_q <= release_d;
    end
  end

`ifdef AUTOREPEAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    pulse_d   = 1'b0;
    release_d = 1'b0;
`ifdef AUTOREPEAT_EN
    // Holding these outside HELD is what pauses the timer in RELEASE_WAIT.
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
`endif

    unique case (state_q)
      StIdle: begin
        level_d = 1'b0;
        if (sync_q) begin
          state_d = StPressWait;
          cnt_d   = '0;
        end
      end

      StPressWait: begin
        if (!sync_q) begin
          // Too short: drop it without touching the outputs.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d = StHeld;
          cnt_d   = '0;
          level_d = 1'b1;
          pulse_d = 1'b1;
`ifdef AUTOREPEAT_EN
          rpt_cnt_d   = '0;
          rpt_first_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      StHeld: begin
        level_d = 1'b1;
        if (!sync_q) begin
          state_d = StReleaseWait;
          cnt_d   = '0;
        end else begin
`ifdef AUTOREPEAT_EN
          if (rpt_cnt_q == rpt_last) begin
            pulse_d     = 1'b1;
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + CntOne;
          end
`endif
        end
      end

      StReleaseWait: begin
        if (sync_q) begin
          // Release bounce: back to HELD with no strobe.
          state_d = StHeld;
          cnt_d   = '0;
`ifdef AUTOREPEAT_EN
          rpt_cnt_d   = '0;
          rpt_first_d = 1'b0;
`endif
        end else if (cnt_q == DebLast) begin
          state_d   = StIdle;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign btn_level   = level_q;
  assign btn_pulse   = pulse_q;
  assign btn_release = release_q;

  // ---------------------------------------------------------------------------
  // Strobe sanity properties
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_strobes_exclusive : assert property (
    @(posedge clk) disable iff (!reset) !(btn_pulse && btn_release));
  a_pulse_single : assert property (
    @(posedge clk) disable iff (!reset) btn_pulse |=> !btn_pulse);
  a_release_single : assert property (
    @(posedge clk) disable iff (!reset) btn_release |=> !btn_release);
`endif

endmodule

// File: tb/tb_button_debounce_pulse.sv
// -----------------------------------------------------------------------------
// tb_button_debounce_pulse
//
// Directed bench for button_debounce_pulse with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=8, REPEAT_PERIOD=4. A vector table covers reset and a clean
// press/release cycle by cycle; hand-written sequences cover glitches, release
// bounce, mid-operation reset, the downstream counter and auto-repeat.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_button_debounce_pulse;

`ifdef AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk;
  logic reset;
  logic btn_in;
  logic btn_level;
  logic btn_pulse;
  logic btn_release;

  button_debounce_pulse #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (8),
    .REPEAT_PERIOD  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_pulse  (btn_pulse),
    .btn_release(btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 4-bit counter driven by btn_pulse as its count enable.
  logic [3:0] ctr;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ctr <= 4'h0;
    else if (btn_pulse) ctr <= ctr + 4'h1;
  end

  // Strobe invariants watched on every falling edge for the whole run.
  logic prev_p = 1'b0;
  logic prev_r = 1'b0;
  int   viol   = 0;
  always_ff @(negedge clk) begin
    prev_p <= btn_pulse;
    prev_r <= btn_release;
    if ((btn_pulse && btn_release) || (btn_pulse && prev_p) || (btn_release && prev_r))
      viol <= viol + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Per-step tallies used by the hand-written sequences.
  int pulses;
  int releases;
  bit lvl_high_seen;
  bit lvl_low_seen;

  task automatic clear_tally();
    pulses        = 0;
    releases      = 0;
    lvl_high_seen = 1'b0;
    lvl_low_seen  = 1'b0;
  endtask

  task automatic step(input logic b);
    btn_in = b;
    @(posedge clk);
    #1;
    if (btn_pulse) pulses++;
    if (btn_release) releases++;
    if (btn_level) lvl_high_seen = 1'b1;
    else lvl_low_seen = 1'b1;
  endtask

  typedef struct packed {
    logic       rst_n;
    logic       btn;
    logic [2:0] exp;  // {btn_level, btn_pulse, btn_release}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic r, input logic b, input logic [2:0] e);
    vec_t v;
    v.rst_n = r;
    v.btn   = b;
    v.exp   = e;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    int got_offs[$];
    int exp_offs[$];
    int first_at;
    int nz;
    logic [3:0] exp_ctr;

    reset  = 1'b0;
    btn_in = 1'b0;

    // ---- Vector table: reset with button held, then press held 20 cycles,
    // ---- then a clean release. Repeats at +8/+12 only with auto-repeat.
    add(10, 1'b0, 1'b1, 3'b000);
    add(6, 1'b1, 1'b1, 3'b000);
    add(1, 1'b1, 1'b1, 3'b110);
    for (int s = 8; s <= 20; s++)
      add(1, 1'b1, 1'b1, {1'b1, AR && (s == 15 || s == 19), 1'b0});
    add(6, 1'b1, 1'b0, 3'b100);
    add(1, 1'b1, 1'b0, 3'b001);
    add(5, 1'b1, 1'b0, 3'b000);

    foreach (vecs[i]) begin
      reset  = vecs[i].rst_n;
      btn_in = vecs[i].btn;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), int'({btn_level, btn_pulse, btn_release}),
            int'(vecs[i].exp));
    end

    // ---- Glitch rejection: 1..4 cycle highs are ignored.
    clear_tally();
    for (int w = 1; w <= 4; w++) begin
      repeat (w) step(1'b1);
      repeat (10) step(1'b0);
    end
    check("glitch_pulses", pulses, 0);
    check("glitch_level", int'(lvl_high_seen), 0);

    // A 5-cycle high is the shortest accepted press.
    clear_tally();
    repeat (5) step(1'b1);
    repeat (10) step(1'b0);
    check("min_press_pulses", pulses, 1);
    check("min_press_releases", releases, 1);

    // ---- Release bounce while held.
    clear_tally();
    repeat (10) step(1'b1);
    check("bounce_press_pulses", pulses, 1);
    clear_tally();
    repeat (3) step(1'b0);
    repeat (5) step(1'b1);
    check("bounce_no_release", releases, 0);
    check("bounce_level_held", int'(lvl_low_seen), 0);
    repeat (12) step(1'b0);
    // Bounce back into HELD restarts the repeat timer at a full period.
    check("bounce_pulses", pulses, AR ? 1 : 0);
    check("bounce_releases", releases, 1);
    check("bounce_level_end", int'(btn_level), 0);

    // ---- Reset mid-operation while the button is held.
    repeat (10) step(1'b1);
    check("held_before_reset", int'(btn_level), 1);
    #2;
    reset = 1'b0;
    #1;
    check("reset_async_drop", int'({btn_level, btn_pulse, btn_release}), 0);
    nz = 0;
    for (int i = 0; i < 6; i++) begin
      step(logic'(i[0]));
      if (btn_level || btn_pulse || btn_release) nz++;
    end
    check("reset_ignores_btn", nz, 0);
    clear_tally();
    reset = 1'b1;
    repeat (6) step(1'b1);
    check("fresh_press_early", pulses, 0);
    step(1'b1);
    check("fresh_press_pulse", int'({btn_level, btn_pulse}), 3);
    repeat (10) step(1'b0);
    check("ctr_after_fresh", int'(ctr), 1);

    // ---- Counter chain: 16 more presses, 17 since reset in total.
    exp_ctr = 4'h1;
    for (int p = 0; p < 16; p++) begin
      repeat (8) step(1'b1);
      repeat (10) step(1'b0);
      exp_ctr = exp_ctr + 4'h1;
      check($sformatf("ctr_press%0d", p + 2), int'(ctr), int'(exp_ctr));
    end
    check("ctr_wrapped", int'(ctr), 1);

    // ---- Auto-repeat: hold 30 cycles after the initial pulse.
    first_at = 0;
    for (int i = 1; i <= 20 && first_at == 0; i++) begin
      step(1'b1);
      if (btn_pulse) first_at = i;
    end
    check("hold_initial_edge", first_at, 7);
    for (int k = 1; k <= 30; k++) begin
      step(1'b1);
      if (btn_pulse) got_offs.push_back(k);
    end
    if (AR) for (int k = 8; k <= 28; k += 4) exp_offs.push_back(k);
    check("repeat_count", got_offs.size(), exp_offs.size());
    for (int i = 0; i < exp_offs.size(); i++)
      check($sformatf("repeat_off%0d", i), (i < got_offs.size()) ? got_offs[i] : -1,
            exp_offs[i]);
    clear_tally();
    repeat (12) step(1'b0);
    check("hold_release", releases, 1);

    check("strobe_invariants", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
